// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: mode-0 SPI master for serial ROM/RAM parts.
// Sends a READ (0x03) or WRITE (0x02) command, an MSB-first address and a burst.
module spi_mem_bridge #(
    parameter int ADDR_W  = 16,
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 1,
    parameter int LEN_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    write,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    input  logic [ADDR_W-1:0]       address,
    input  logic [LEN_W-1:0]        len,
    input  logic [7:0]              wdata,
    output logic                    wdata_ready,
    output logic [7:0]              rdata,
    output logic                    rdata_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [NUM_CS-1:0]       cs_n
);

    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AB    = ADDR_W / 8;
    localparam int BC_W  = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [BC_W-1:0]   byte_q, byte_d;
    logic [7:0]        tx_q, tx_d;
    logic [6:0]        rx_q, rx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              wr_q, wr_d;

    logic              sclk_d, mosi_d;
    logic [NUM_CS-1:0] cs_n_d;
    logic              busy_d, done_d, err_d;
    logic              wready_d, rvalid_d;
    logic [7:0]        rdata_d;
    logic [7:0]        nb;
    logic              tick;
    logic              cs_ok;

    assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign cs_ok = ({1'b0, cs_sel} < (CS_W + 1)'(NUM_CS));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wr_d     = wr_q;
        sclk_d   = sclk;
        mosi_d   = mosi;
        cs_n_d   = cs_n;
        busy_d   = busy;
        rdata_d  = rdata;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wready_d = 1'b0;
        rvalid_d = 1'b0;
        nb       = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (start && cs_ok) begin
                    state_d = CMD;
                    wr_d    = write;
                    addr_d  = address;
                    len_d   = len;
                    busy_d  = 1'b1;
                    for (int i = 0; i < NUM_CS; i++)
                        cs_n_d[i] = (CS_W'(i) != cs_sel);
                    nb      = write ? 8'h02 : 8'h03;
                    mosi_d  = nb[7];
                    tx_d    = {nb[6:0], 1'b0};
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end

            CMD, ADDR, DATA: begin
                if (!tick) begin
                    div_d = div_q + 1'b1;
                end else if (!sclk) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                end else begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[5:0], miso};
                    if (bit_q != 3'd7) begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end else begin
                        // byte boundary: pick the next byte to shift
                        bit_d  = '0;
                        byte_d = byte_q + 1'b1;
                        if (state_q == DATA && !wr_q) begin
                            rdata_d  = {rx_q, miso};
                            rvalid_d = 1'b1;
                        end
                        if (state_q == CMD) begin
                            state_d = ADDR;
                            byte_d  = '0;
                            nb      = addr_q[ADDR_W-1 -: 8];
                            addr_d  = addr_q << 8;
                        end else if (state_q == ADDR) begin
                            if (byte_q == BC_W'(AB - 1)) begin
                                state_d  = DATA;
                                byte_d   = '0;
                                nb       = wr_q ? wdata : 8'h00;
                                wready_d = wr_q;
                            end else begin
                                nb     = addr_q[ADDR_W-1 -: 8];
                                addr_d = addr_q << 8;
                            end
                        end else if (byte_q == {1'b0, len_q}) begin
                            state_d = FINISH;
                            cs_n_d  = '1;
                            done_d  = 1'b1;
                        end else begin
                            nb       = wr_q ? wdata : 8'h00;
                            wready_d = wr_q;
                        end
                        mosi_d = nb[7];
                        tx_d   = {nb[6:0], 1'b0};
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wr_q        <= 1'b0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= '1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            sclk        <= sclk_d;
            mosi        <= mosi_d;
            cs_n        <= cs_n_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            wdata_ready <= wready_d;
            rdata_valid <= rvalid_d;
            rdata       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: directed checks of spi_mem_bridge against a small
// behavioural SPI memory (16-bit/div 1) and a pattern slave (24-bit/div 3).
`timescale 1ns/1ps
module tb_spi_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // DUT 1: ADDR_W=16, NUM_CS=2, CLK_DIV=1
    logic        start1, write1, cs_sel1;
    logic [15:0] addr1;
    logic [3:0]  len1;
    logic [7:0]  wdata1, rdata1;
    logic        wready1, rvalid1, busy1, done1, err1;
    logic        sclk1, mosi1, miso1;
    logic [1:0]  cs_n1;

    // DUT 2: ADDR_W=24, NUM_CS=3, CLK_DIV=3
    logic        start2, write2;
    logic [1:0]  cs_sel2;
    logic [23:0] addr2;
    logic [3:0]  len2;
    logic [7:0]  wdata2, rdata2;
    logic        wready2, rvalid2, busy2, done2, err2;
    logic        sclk2, mosi2, miso2;
    logic [2:0]  cs_n2;

    spi_mem_bridge #(
        .ADDR_W(16), .NUM_CS(2), .CLK_DIV(1), .LEN_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .write(write1),
        .cs_sel(cs_sel1), .address(addr1), .len(len1),
        .wdata(wdata1), .wdata_ready(wready1), .rdata(rdata1),
        .rdata_valid(rvalid1), .busy(busy1), .done(done1),
        .err(err1), .sclk(sclk1), .mosi(mosi1), .miso(miso1),
        .cs_n(cs_n1)
    );

    spi_mem_bridge #(
        .ADDR_W(24), .NUM_CS(3), .CLK_DIV(3), .LEN_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .write(write2),
        .cs_sel(cs_sel2), .address(addr2), .len(len2),
        .wdata(wdata2), .wdata_ready(wready2), .rdata(rdata2),
        .rdata_valid(rvalid2), .busy(busy2), .done(done2),
        .err(err2), .sclk(sclk2), .mosi(mosi2), .miso(miso2),
        .cs_n(cs_n2)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT 1 monitors and memory model ----------------
    int rv1_cnt = 0, wr1_cnt = 0, done1_cnt = 0;
    int cs0_lo = 0, cs1_lo = 0;

    assign wdata1 = (wr1_cnt == 0) ? 8'h11 :
                    (wr1_cnt == 1) ? 8'h22 : 8'h33;

    always @(negedge clk) begin
        if (rvalid1) rv1_cnt++;
        if (wready1) wr1_cnt++;
        if (done1) done1_cnt++;
        if (!cs_n1[0]) cs0_lo++;
        if (!cs_n1[1]) cs1_lo++;
    end

    logic [7:0]  mem [1024];
    logic [7:0]  log1 [16];
    int          nlog = 0, mb = 0, mbyte = 0;
    logic [7:0]  m_in = 8'h00, m_out = 8'h00;
    logic [15:0] m_addr = 16'h0000;
    logic        m_wr = 1'b0, p_cs1 = 1'b1, p_s1 = 1'b0;
    wire         cs_all1 = &cs_n1;

    always @(negedge clk) begin
        if (rst) begin
            mem[10'h234] = 8'hA5;
            p_cs1 = 1'b1;
            p_s1  = 1'b0;
            miso1 = 1'b0;
        end else begin
            if (p_cs1 && !cs_all1) begin
                mb = 0; mbyte = 0; nlog = 0;
                m_out = 8'h00; miso1 = 1'b0;
            end
            if (!cs_all1 && sclk1 && !p_s1) begin
                m_in = {m_in[6:0], mosi1};
                mb++;
                if (mb == 8) begin
                    mb = 0;
                    if (nlog < 16) log1[nlog] = m_in;
                    nlog++;
                    if (mbyte == 0) m_wr = (m_in == 8'h02);
                    else if (mbyte < 3) m_addr = {m_addr[7:0], m_in};
                    else if (m_wr) begin
                        mem[m_addr[9:0]] = m_in;
                        m_addr++;
                    end
                    mbyte++;
                    if (!m_wr && mbyte >= 3) begin
                        m_out = mem[m_addr[9:0]];
                        m_addr++;
                    end
                end
            end
            if (!cs_all1 && !sclk1 && p_s1) begin
                miso1 = m_out[7];
                m_out = {m_out[6:0], 1'b0};
            end
            p_cs1 = cs_all1;
            p_s1  = sclk1;
        end
    end

    function automatic logic [7:0] lb(input int i);
        return (i < nlog && i < 16) ? log1[i] : 8'hEE;
    endfunction

    // ---------------- DUT 2 pattern slave and phase monitor ----------------
    logic [47:0] pat2 = 48'h0;
    logic [63:0] sh2 = 64'h0;
    int          n2 = 0, rise2 = 0, run2 = 0, err2_cnt = 0, rv2_cnt = 0;
    int          hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
    logic [7:0]  r2a = 8'h00, r2b = 8'h00;
    logic        p_cs2 = 1'b1, p_s2 = 1'b0;
    wire         cs_all2 = &cs_n2;

    assign miso2 = pat2[47];

    always @(negedge clk) begin
        if (err2) err2_cnt++;
        if (rvalid2) begin
            if (rv2_cnt == 0) r2a = rdata2;
            else r2b = rdata2;
            rv2_cnt++;
        end
        if (p_cs2 && !cs_all2) begin
            pat2 = 48'h0000_0000_C35A;
            sh2  = 64'h0;
            n2   = 0;
        end
        if (sclk2 && !p_s2) begin
            rise2++;
            sh2 = {sh2[62:0], mosi2};
            n2++;
        end
        if (!sclk2 && p_s2 && !cs_all2) pat2 = {pat2[46:0], 1'b0};
        if (!cs_all2 || run2 > 0) begin
            if (!cs_all2 && sclk2 == p_s2) begin
                run2++;
            end else begin
                if (run2 > 0) begin
                    if (p_s2) begin
                        if (run2 < hi_min) hi_min = run2;
                        if (run2 > hi_max) hi_max = run2;
                    end else begin
                        if (run2 < lo_min) lo_min = run2;
                        if (run2 > lo_max) lo_max = run2;
                    end
                end
                run2 = cs_all2 ? 0 : 1;
            end
        end
        p_cs2 = cs_all2;
        p_s2  = sclk2;
    end

    // drive start at a negedge, return at the FINISH-cycle negedge
    task automatic go1(input logic w, input logic cs, input logic [15:0] a,
                       input logic [3:0] l, output int lat);
        start1 = 1'b1; write1 = w; cs_sel1 = cs; addr1 = a; len1 = l;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, b0, b1, b2;

    initial begin
        rst = 1'b1;
        start1 = 0; write1 = 0; cs_sel1 = 0; addr1 = 0; len1 = 0;
        start2 = 0; write2 = 0; cs_sel2 = 0; addr2 = 0; len2 = 0;
        wdata2 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n1", cs_n1, 2'b11);
        check("rst_cs_n2", cs_n2, 3'b111);
        check("rst_sclk", {sclk1, sclk2}, 2'b00);
        check("rst_mosi", {mosi1, mosi2}, 2'b00);
        check("rst_flags", {busy1, done1, err1, wready1, rvalid1}, 5'b0);
        check("rst_rdata", rdata1, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // single-byte read, cs 0
        b0 = cs0_lo; b1 = cs1_lo; b2 = rv1_cnt;
        go1(1'b0, 1'b0, 16'h1234, 4'd0, lat);
        check("rd_latency", lat, 64);
        check("rd_fin_cs_n", cs_n1, 2'b11);
        check("rd_fin_sclk", sclk1, 1'b0);
        check("rd_fin_busy", busy1, 1'b1);
        @(negedge clk);
        check("rd_idle_busy", {busy1, done1}, 2'b00);
        check("rd_mosi", {lb(0), lb(1), lb(2), lb(3)}, 32'h03123400);
        check("rd_nbytes", nlog, 4);
        check("rd_data", rdata1, 8'hA5);
        check("rd_valid_cnt", rv1_cnt - b2, 1);
        check("rd_cs0_low", cs0_lo - b0, 64);
        check("rd_cs1_high", cs1_lo - b1, 0);

        // three-byte write burst, cs 1
        b0 = cs0_lo; b1 = cs1_lo; b2 = wr1_cnt;
        go1(1'b1, 1'b1, 16'h00FF, 4'd2, lat);
        check("wr_latency", lat, 96);
        @(negedge clk);
        check("wr_mosi_hi", {lb(0), lb(1), lb(2), lb(3)}, 32'h0200FF11);
        check("wr_mosi_lo", {lb(4), lb(5)}, 16'h2233);
        check("wr_nbytes", nlog, 6);
        check("wr_ready_cnt", wr1_cnt - b2, 3);
        check("wr_mem", {mem[10'h0FF], mem[10'h100], mem[10'h101]},
              24'h112233);
        check("wr_cs0_high", cs0_lo - b0, 0);
        check("wr_cs1_low", cs1_lo - b1, 96);

        // start held high: FINISH, one IDLE, then the next CMD
        start1 = 1'b1; write1 = 1'b0; cs_sel1 = 1'b0;
        addr1 = 16'h1234; len1 = 4'd0;
        @(negedge clk);
        lat = 0;
        while (!done1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat1", lat, 64);
        @(negedge clk);
        check("b2b_idle", {busy1, cs_n1}, 3'b011);
        @(negedge clk);
        check("b2b_restart", {busy1, cs_n1}, 3'b110);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat2", lat, 64);
        @(negedge clk);
        check("b2b_data", rdata1, 8'hA5);

        // reset in the middle of the first address byte
        start1 = 1'b1; write1 = 1'b0; cs_sel1 = 1'b0;
        addr1 = 16'h1234; len1 = 4'd0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (21) @(negedge clk);
        check("abort_pre", {busy1, sclk1, cs_n1}, 4'b1110);
        b0 = done1_cnt;
        #2 rst = 1'b1;
        #1;
        check("abort_async", {busy1, sclk1, cs_n1}, 4'b0011);
        repeat (2) @(negedge clk);
        check("abort_no_done", done1_cnt - b0, 0);
        check("abort_rdata_clr", rdata1, 8'h00);
        rst = 1'b0;
        go1(1'b0, 1'b0, 16'h1234, 4'd0, lat);
        check("post_abort_lat", lat, 64);
        @(negedge clk);
        check("post_abort_data", rdata1, 8'hA5);

        // DUT 2: out-of-range chip select is rejected
        b0 = rise2; b1 = err2_cnt;
        start2 = 1'b1; cs_sel2 = 2'd3; write2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        check("err_pulse", {err2, busy2, cs_n2}, 5'b10111);
        @(negedge clk);
        check("err_clear", err2, 1'b0);
        repeat (5) @(negedge clk);
        check("err_once", err2_cnt - b1, 1);
        check("err_no_sclk", rise2 - b0, 0);
        check("err_cs_n", cs_n2, 3'b111);

        // DUT 2: 24-bit read burst of 2, divider 3
        b0 = rise2;
        start2 = 1'b1; cs_sel2 = 2'd2; write2 = 1'b0;
        addr2 = 24'hABCDEF; len2 = 4'd1;
        @(negedge clk);
        start2 = 1'b0;
        check("d3_cs_n", cs_n2, 3'b011);
        lat = 0;
        while (!done2 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("d3_latency", lat, 288);
        @(negedge clk);
        check("d3_hi_phase", {hi_min[7:0], hi_max[7:0]}, 16'h0303);
        check("d3_lo_phase", {lo_min[7:0], lo_max[7:0]}, 16'h0303);
        check("d3_rises", rise2 - b0, 48);
        check("d3_cmd_addr", sh2[47:16], 32'h03ABCDEF);
        check("d3_read_mosi", sh2[15:0], 16'h0000);
        check("d3_nbits", n2, 48);
        check("d3_rvalid_cnt", rv2_cnt, 2);
        check("d3_rdata", {r2a, r2b}, 16'hC35A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
